// File: rtl/cal_lut_pkg.sv
// Shared constants, FSM state type and bit-count helper
// for the calibration LUT serial loader.
package cal_lut_pkg;

  localparam int N_ADDR_DEF = 7;
  localparam int N_LUT_DEF  = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    FINISH
  } state_t;

  function automatic int total_bits(input int n_addr,
                                    input int n_lut);
    return (1 << n_addr) * n_lut;
  endfunction

endpackage

// File: rtl/cal_lut_loader_divider.sv
// Phase counter for cal_clk: strobes phase_end on the last
// clk cycle of each HALF_PERIOD-long phase.
module cal_lut_loader_divider
  import cal_lut_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic phase_end
);

  localparam int CW = (HALF_PERIOD > 1) ?
                      $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign phase_end = run &&
                     (cnt == CW'(HALF_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || !run || phase_end)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cal_lut_loader.sv
// Calibration LUT table + serial shifter to the sensor.
// Option: CAL_LUT_LOADER_AUTO_ENA_EN gates cal_ena on a completed load.
module cal_lut_loader
  import cal_lut_pkg::*;
#(
  parameter int N_ADDR      = N_ADDR_DEF,
  parameter int N_LUT       = N_LUT_DEF,
  parameter int HALF_PERIOD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [N_ADDR-1:0] wr_addr,
  input  logic [N_LUT-1:0]  wr_data,
  input  logic              start,
  input  logic              cal_ena_req,
  output logic              busy,
  output logic              done,
  output logic              cal_clk,
  output logic              cal_dat,
  output logic              cal_ena
);

  localparam int DEPTH  = 1 << N_ADDR;
  localparam int N_BITS = total_bits(N_ADDR, N_LUT);
  localparam int IW     = $clog2(N_BITS);
  localparam int BW     = (N_LUT > 1) ? $clog2(N_LUT) : 1;

  state_t state;

  logic [N_LUT-1:0]  lut [DEPTH];
  logic [IW-1:0]     idx;
  logic [N_ADDR-1:0] ent;
  logic [BW-1:0]     bsel;
  logic [N_ADDR-1:0] nxt_ent;
  logic [BW-1:0]     nxt_bit;
  logic              phase_end;
  logic              run;
  logic              last;

  assign run  = (state == LOW) || (state == HIGH);
  assign last = (idx == IW'(N_BITS - 1));

  cal_lut_loader_divider #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .phase_end(phase_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        lut[i] <= '0;
    end else if (wr_en && state == IDLE) begin
      lut[wr_addr] <= wr_data;
    end
  end

  // Entry counts down once the bit counter has covered the entry
  always_comb begin
    nxt_ent = ent;
    nxt_bit = bsel - 1'b1;
    if (bsel == '0) begin
      nxt_ent = ent - 1'b1;
      nxt_bit = BW'(N_LUT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cal_clk <= 1'b0;
      cal_dat <= 1'b0;
      idx     <= '0;
      ent     <= '1;
      bsel    <= BW'(N_LUT - 1);
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cal_clk <= 1'b0;
          cal_dat <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            state   <= LOW;
            busy    <= 1'b1;
            idx     <= '0;
            ent     <= '1;
            bsel    <= BW'(N_LUT - 1);
            cal_dat <= lut[DEPTH-1][N_LUT-1];
          end
        end
        LOW: begin
          if (phase_end) begin
            state   <= HIGH;
            cal_clk <= 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            cal_clk <= 1'b0;
            if (last) begin
              state   <= FINISH;
              cal_dat <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              idx     <= '0;
              ent     <= '1;
              bsel    <= BW'(N_LUT - 1);
            end else begin
              state   <= LOW;
              idx     <= idx + 1'b1;
              ent     <= nxt_ent;
              bsel    <= nxt_bit;
              cal_dat <= lut[nxt_ent][nxt_bit];
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CAL_LUT_LOADER_AUTO_ENA_EN
  logic loaded;

  always_ff @(posedge clk) begin
    if (reset) begin
      loaded  <= 1'b0;
      cal_ena <= 1'b0;
    end else begin
      cal_ena <= cal_ena_req & loaded;
      if (state == IDLE && start)
        loaded <= 1'b0;
      else if (state == FINISH)
        loaded <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)
      cal_ena <= 1'b0;
    else
      cal_ena <= cal_ena_req;
  end
`endif

endmodule

// File: tb/tb_cal_lut_loader.sv
// Directed bench for cal_lut_loader: table load, bit order,
// timing, busy-time isolation, abort and cal_ena behaviour.
module tb_cal_lut_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [6:0] wr_data;
  logic       start;
  logic       cal_ena_req;
  logic       busy;
  logic       done;
  logic       cal_clk;
  logic       cal_dat;
  logic       cal_ena;

  int checks = 0;
  int errors = 0;

  logic [895:0] model = '0;
  int rises    = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  logic [6:0] exp_t [128];

  cal_lut_loader dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .cal_ena_req(cal_ena_req),
    .busy       (busy),
    .done       (done),
    .cal_clk    (cal_clk),
    .cal_dat    (cal_dat),
    .cal_ena    (cal_ena)
  );

  always #5 clk = ~clk;

  always @(posedge cal_clk) begin
    model <= {model[894:0], cal_dat};
    rises <= rises + 1;
  end

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic write_entry(input logic [6:0] a,
                             input logic [6:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_xfer(input bit disturb,
                          output int nr,
                          output int nb,
                          output int nd);
    int r0, b0, d0, n;
    r0 = rises; b0 = busy_cyc; d0 = done_cnt; n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (done !== 1'b1 && n < 5000) begin
      if (disturb && n == 100) begin
        wr_en = 1'b1; wr_addr = 7'd5;
        wr_data = ~exp_t[5]; start = 1'b1;
      end else if (disturb && n == 2000) begin
        start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk); n++;
    end
    wr_en = 1'b0; start = 1'b0;
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL xfer_timeout waited %0d cycles, required done", n);
    end
    repeat (2) @(negedge clk);
    nr = rises - r0;
    nb = busy_cyc - b0;
    nd = done_cnt - d0;
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_done got %b want 0", done);
    end
    checks++;
    if (cal_clk !== 1'b0) begin
      errors++; $display("FAIL rst_cal_clk got %b want 0", cal_clk);
    end
    checks++;
    if (cal_dat !== 1'b0) begin
      errors++; $display("FAIL rst_cal_dat got %b want 0", cal_dat);
    end
    checks++;
    if (cal_ena !== 1'b0) begin
      errors++; $display("FAIL rst_cal_ena got %b want 0", cal_ena);
    end
    reset = 1'b0; start = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({busy, done, cal_clk, cal_dat, cal_ena} !== 5'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_outputs nonzero in %0d cycles, want 0", bad);
    end
  endtask

  task automatic test_pattern;
    int nr, nb, nd;
    logic [6:0] f7, l7;
    write_entry(7'd127, 7'h55);
    write_entry(7'd0, 7'h01);
    run_xfer(1'b0, nr, nb, nd);
    f7 = model[895:889];
    l7 = model[6:0];
    checks++;
    if (f7 !== 7'b1010101) begin
      errors++; $display("FAIL first7 got %b want 1010101", f7);
    end
    checks++;
    if (l7 !== 7'b0000001) begin
      errors++; $display("FAIL last7 got %b want 0000001", l7);
    end
    checks++;
    if (model[888:7] !== '0) begin
      errors++; $display("FAIL middle_bits nonzero, want all 0");
    end
    checks++;
    if (nr != 896) begin
      errors++; $display("FAIL rises got %0d want 896", nr);
    end
    checks++;
    if (nb != 3584) begin
      errors++; $display("FAIL busy_cycles got %0d want 3584", nb);
    end
    checks++;
    if (nd != 1) begin
      errors++; $display("FAIL done_pulses got %0d want 1", nd);
    end
  endtask

  task automatic test_random_table;
    int nr, nb, nd;
    logic [6:0] got;
    for (int i = 0; i < 128; i++) begin
      exp_t[i] = 7'($urandom_range(0, 127));
      write_entry(7'(i), exp_t[i]);
    end
    run_xfer(1'b0, nr, nb, nd);
    checks++;
    if (nr != 896) begin
      errors++; $display("FAIL rand_rises got %0d want 896", nr);
    end
    for (int i = 0; i < 128; i++) begin
      got = model[i*7 +: 7];
      checks++;
      if (got !== exp_t[i]) begin
        errors++;
        $display("FAIL rand_entry[%0d] got %h want %h", i, got, exp_t[i]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int nr, nb, nd, bad;
    logic [6:0] got;
    run_xfer(1'b1, nr, nb, nd);
    checks++;
    if (nr != 896) begin
      errors++; $display("FAIL dist_rises got %0d want 896", nr);
    end
    checks++;
    if (nb != 3584) begin
      errors++; $display("FAIL dist_busy got %0d want 3584", nb);
    end
    checks++;
    if (nd != 1) begin
      errors++; $display("FAIL dist_done got %0d want 1", nd);
    end
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (model[i*7 +: 7] !== exp_t[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL dist_stream %0d entries differ, want 0", bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL dist_restart busy got %b want 0", busy);
    end
    run_xfer(1'b0, nr, nb, nd);
    got = model[5*7 +: 7];
    checks++;
    if (got !== exp_t[5]) begin
      errors++; $display("FAIL entry5_kept got %h want %h", got, exp_t[5]);
    end
  endtask

  task automatic test_reset_abort;
    int r0, d0, n, nr, nb, nd;
    r0 = rises; n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while ((rises - r0) < 300 && n < 5000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++; $display("FAIL abort_wait timeout, rises %0d want 300", rises - r0);
    end
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cal_clk !== 1'b0) begin
      errors++; $display("FAIL abort_cal_clk got %b want 0", cal_clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy got %b want 0", busy);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet done %0d busy %b want 0 0", done_cnt - d0, busy);
    end
    write_entry(7'd127, 7'h40);
    run_xfer(1'b0, nr, nb, nd);
    checks++;
    if (model[895:889] !== 7'h40) begin
      errors++; $display("FAIL restart_first got %h want 40", model[895:889]);
    end
    checks++;
    if (model[888:0] !== '0) begin
      errors++; $display("FAIL restart_cleared table nonzero, want 0");
    end
    checks++;
    if (nr != 896 || nd != 1) begin
      errors++; $display("FAIL restart_count rises %0d done %0d want 896 1", nr, nd);
    end
  endtask

  task automatic test_cal_ena;
`ifdef CAL_LUT_LOADER_AUTO_ENA_EN
    int n, bad;
    reset = 1'b1; cal_ena_req = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cal_ena !== 1'b0) begin
      errors++; $display("FAIL ena_unloaded got %b want 0", cal_ena);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; bad = 0;
    while (done !== 1'b1 && n < 5000) begin
      if (cal_ena !== 1'b0) bad++;
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 5000 || bad != 0) begin
      errors++; $display("FAIL ena_busy high %0d cycles, wait %0d, want 0", bad, n);
    end
    checks++;
    if (cal_ena !== 1'b0) begin
      errors++; $display("FAIL ena_at_done got %b want 0", cal_ena);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cal_ena !== 1'b1) begin
      errors++; $display("FAIL ena_after_done got %b want 1", cal_ena);
    end
`else
    reset = 1'b1; cal_ena_req = 1'b1;
    @(negedge clk);
    checks++;
    if (cal_ena !== 1'b0) begin
      errors++; $display("FAIL ena_in_reset got %b want 0", cal_ena);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cal_ena !== 1'b1) begin
      errors++; $display("FAIL ena_after_rel got %b want 1", cal_ena);
    end
    cal_ena_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cal_ena !== 1'b0) begin
      errors++; $display("FAIL ena_drop got %b want 0", cal_ena);
    end
`endif
    cal_ena_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; cal_ena_req = 1'b0;
    test_reset();
    test_pattern();
    test_random_table();
    test_busy_ignore();
    test_reset_abort();
    test_cal_ena();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_lut_loader.md
# cal_lut_loader

Serial transmitter for the temperature sensor's calibration LUT shift register. It holds a local 128-entry × 7-bit calibration table, written over a simple parallel port. On request it shifts the whole table out on `cal_clk`/`cal_dat` in the bit order the sensor-side shift register expects, then drives `cal_ena`. It sits on the host/test-controller side of the `ui_in[2:0]` calibration interface.

## Interface
- `N_ADDR`, 7: address width; table depth is 2**N_ADDR entries.
- `N_LUT`, 7: entry width in bits.
- `HALF_PERIOD`, 2: clk cycles per `cal_clk` phase; legal range ≥1.

- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  N_ADDR  table write address.
- `wr_data`  in  N_LUT  table write data.
- `start`  in  1  request serial load; single-cycle or level.
- `cal_ena_req`  in  1  host request to enable calibration.
- `busy`  out  1  serial transfer in progress.
- `done`  out  1  one-cycle pulse at transfer completion.
- `cal_clk`  out  1  serial shift clock to sensor.
- `cal_dat`  out  1  serial data to sensor.
- `cal_ena`  out  1  calibration-enable to sensor.

## Operation
- Table: 2**N_ADDR × N_LUT registers.
  - Reset value is 0 for all entries.
  - `wr_en` in IDLE writes `wr_data` to `wr_addr` on the next edge.
  - `wr_en` during transfer (busy=1) is ignored; the table stays frozen.
- Bit order: 2**N_ADDR·N_LUT bits (896 at defaults).
  - Entries go highest address first: 127 down to 0.
  - Within an entry, MSB first.
  - First bit sent is entry[127][6]; last is entry[0][0].
- FSM states: IDLE, LOW, HIGH, FINISH.
  - IDLE: `cal_clk`=0, `cal_dat`=0, busy=0. `start`=1 → LOW with bit index 0 and phase counter 0.
  - LOW: `cal_clk`=0, `cal_dat`=current bit. After HALF_PERIOD cycles → HIGH.
  - HIGH: `cal_clk`=1, `cal_dat` unchanged. After HALF_PERIOD cycles:
    - index < last → LOW with index+1;
    - index = last → FINISH.
  - FINISH: one cycle. `cal_clk`=0, `cal_dat`=0, `done`=1, busy=0 → IDLE.
- `start` is ignored outside IDLE. `start` held high re-triggers a new transfer the cycle after FINISH.
- Bit index is a 10-bit counter (⌈log2(896)⌉). Entry select = 127 − index/7; bit select = 6 − index%7.
  - Implement as nested entry/bit down-counters, not a divider.
  - Entry counter wraps from 0 only at transfer end.
- Reset mid-transfer: next cycle goes to IDLE, `cal_clk`=0, the transfer is aborted, and no `done` is produced. Table contents are also cleared.
- All outputs are registered.

## Timing
- Reset values: busy=0, done=0, `cal_clk`=0, `cal_dat`=0, `cal_ena`=0.
- `start` sampled at edge T → busy=1, LOW, `cal_dat`=bit 0 from T+1.
- First `cal_clk` rise at T+1+HALF_PERIOD.
- `cal_dat` changes only in the same cycle `cal_clk` falls. Setup and hold to the rising edge are each HALF_PERIOD cycles.
- busy stays high for exactly 896·2·HALF_PERIOD cycles (3584 at defaults). `done` pulses in the following cycle.
- Write-to-transfer: a write accepted at edge T is visible to a `start` sampled at T+1.

## Configuration
- `CAL_LUT_LOADER_AUTO_ENA_EN` defined:
  - An internal `loaded` flag is cleared by reset and at transfer start, and set in FINISH.
  - `cal_ena` = registered (`cal_ena_req` & `loaded`). It is therefore 0 throughout any transfer and until one completes.
- Undefined:
  - `cal_ena` = `cal_ena_req` registered, one-cycle latency, independent of transfer state.

## Structure
- Shared package `cal_lut_pkg`:
  - default N_ADDR/N_LUT constants;
  - FSM state enum (IDLE, LOW, HIGH, FINISH);
  - total-bit-count localparam function.
- Sub-module `cal_lut_loader_divider`: HALF_PERIOD phase counter producing a one-cycle `phase_end` strobe; cleared by reset and in IDLE.
- Table storage and FSM stay in the top module.

## Test plan
- Reset then idle 10 cycles → all outputs 0; `start` during reset → no transfer.
- Write entry[127]=7'h55, entry[0]=7'h01, others 0; `start` → first 7 bits on `cal_clk` rises are 1,0,1,0,1,0,1; last 7 bits are 0,0,0,0,0,0,1; exactly 896 rises; busy=3584 cycles; single `done` pulse.
- Full random table load into a bench-side 896-bit shift model clocked by `cal_clk` → every model entry[i] matches the written entry[i].
- `wr_en` to entry[5] during busy and `start` pulses mid-transfer → stream unchanged, no restart, entry[5] retains its old value afterwards.
- Assert reset at bit 300 → `cal_clk`=0 and busy=0 the next cycle, no `done`; a fresh `start` restarts from entry[127][6] (table now zero).
- `cal_ena_req`=1 throughout:
  - with `CAL_LUT_LOADER_AUTO_ENA_EN`: `cal_ena`=0 until one cycle after `done`, then 1;
  - without it: `cal_ena`=1 one cycle after reset release.
